// File: rtl/line_buffer3.sv
// Two-row line buffer feeding a 3x3 window stage: emits vertically aligned pixel triples.
// Optional top-border zero padding is enabled by defining LINE_BUFFER3_ZERO_PAD_EN.
module line_buffer3 #(
    parameter int BIT_DEPTH  = 8,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int COL_W      = $clog2(IMG_WIDTH),
    parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BIT_DEPTH-1:0] pix_in,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic [BIT_DEPTH-1:0] out1,
    output logic [BIT_DEPTH-1:0] out2,
    output logic [BIT_DEPTH-1:0] out3,
    output logic                 out_valid,
    output logic [COL_W-1:0]     col_idx,
    output logic                 frame_done,
    output logic [1:0]           state_dbg
);

    // Handshake: a pixel is consumed on a rising edge where pix_valid && pix_ready;
    // out1..out3/col_idx are valid on the cycle after that edge when out_valid is high.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               state_q;
    logic [COL_W-1:0]     col_cnt_q;
    logic [ROW_W-1:0]     row_cnt_q;
    logic [BIT_DEPTH-1:0] out1_q, out2_q, out3_q;
    logic                 out_valid_q;
    logic [COL_W-1:0]     col_idx_q;

    logic [BIT_DEPTH-1:0] line0_q [IMG_WIDTH];
    logic [BIT_DEPTH-1:0] line1_q [IMG_WIDTH];

    logic                 accept;
    logic                 last_col;
    logic                 last_row;
    logic [BIT_DEPTH-1:0] rd0, rd1;
    logic [BIT_DEPTH-1:0] out1_d, out2_d;
    logic                 out_valid_d;

    assign pix_ready = (state_q == S_FILL) || (state_q == S_STREAM);
    assign accept    = pix_valid && pix_ready;
    assign last_col  = (col_cnt_q == COL_W'(IMG_WIDTH - 1));
    assign last_row  = (row_cnt_q == ROW_W'(IMG_HEIGHT - 1));
    assign rd0       = line0_q[col_cnt_q];
    assign rd1       = line1_q[col_cnt_q];

    always_comb begin
        out1_d      = rd0;
        out2_d      = rd1;
        out_valid_d = (state_q == S_STREAM);
`ifdef LINE_BUFFER3_ZERO_PAD_EN
        // Rows above the image read as zero; memories still fill normally.
        out_valid_d = 1'b1;
        if (row_cnt_q == '0) begin
            out1_d = '0;
            out2_d = '0;
        end else if (row_cnt_q == ROW_W'(1)) begin
            out1_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            out3_q      <= '0;
            out_valid_q <= 1'b0;
            col_idx_q   <= '0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_FILL;
                        col_cnt_q <= '0;
                        row_cnt_q <= '0;
                    end
                end
                S_FILL, S_STREAM: begin
                    if (accept) begin
                        out1_q      <= out1_d;
                        out2_q      <= out2_d;
                        out3_q      <= pix_in;
                        col_idx_q   <= col_cnt_q;
                        out_valid_q <= out_valid_d;
                        if (last_col) begin
                            col_cnt_q <= '0;
                            if (last_row) begin
                                row_cnt_q <= '0;
                                state_q   <= S_DONE;
                            end else begin
                                row_cnt_q <= row_cnt_q + 1'b1;
                                if (row_cnt_q == ROW_W'(1)) state_q <= S_STREAM;
                            end
                        end else begin
                            col_cnt_q <= col_cnt_q + 1'b1;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Line memories are deliberately left unreset; FILL overwrites them each frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            line0_q[col_cnt_q] <= rd1;
            line1_q[col_cnt_q] <= pix_in;
        end
    end

    assign out1       = out1_q;
    assign out2       = out2_q;
    assign out3       = out3_q;
    assign out_valid  = out_valid_q;
    assign col_idx    = col_idx_q;
    assign frame_done = (state_q == S_DONE);
    assign state_dbg  = state_q;

endmodule
